// File: rtl/imem_loadable_if.sv
// rtl/imem_loadable_if.sv - fetch and program-load signal bundle for imem_loadable
interface imem_loadable_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic [PC_W-1:0]   pc;
  logic              fetch_en;
  logic              stall;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              fetch_fault;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_busy;

  modport master (
    output pc, fetch_en, stall, load_start, load_valid, load_data, load_last,
    input  instruction, instr_valid, fetch_fault, load_ready, load_busy
  );

  modport slave (
    input  pc, fetch_en, stall, load_start, load_valid, load_data, load_last,
    output instruction, instr_valid, fetch_fault, load_ready, load_busy
  );
endinterface

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - run-time loadable instruction memory with registered fetch
module imem_loadable #(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 256,
  parameter int                PC_W         = 32,
  parameter int                PC_BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP_WORD     = '0
) (
  input logic       clk,
  input logic       rst,
  imem_loadable_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_fault;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_load_ready;
  logic              w_beat;
  logic              w_ptr_last;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [PC_W-1:0]   w_index;
  logic              w_misaligned;
  logic              w_oob;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_load_ready = (r_state == S_LOAD) && !bus.load_start;
  assign w_beat       = w_load_ready && bus.load_valid;
  assign w_ptr_last   = (r_ptr == IDX_W'(DEPTH - 1));
  assign w_we         = !rst && ((r_state == S_CLEAR) || w_beat);
  assign w_wdata      = (r_state == S_CLEAR) ? NOP_WORD : bus.load_data;

  assign w_index      = (PC_BYTE_ADDR != 0) ? (bus.pc >> 2) : bus.pc;
  assign w_misaligned = (PC_BYTE_ADDR != 0) && (bus.pc[1:0] != 2'b00);
  assign w_oob        = (w_index >= PC_W'(DEPTH));
  assign w_rd_idx     = w_index[IDX_W-1:0];

  // Single write port shared by the clear sweep and the loader.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (!bus.stall) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
          end
          if (w_ptr_last) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + IDX_W'(1);
          end
        end
        S_LOAD: begin
          if (!bus.stall) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
          end
          if (bus.load_start) begin
            r_ptr <= '0;
          end else if (w_beat) begin
            // No wrap: a full memory ends the load even without load_last.
            if (bus.load_last || w_ptr_last) begin
              r_state <= S_RUN;
              r_ptr   <= '0;
            end else begin
              r_ptr <= r_ptr + IDX_W'(1);
            end
          end
        end
        S_RUN: begin
          if (bus.load_start) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
            r_valid <= 1'b0;
          end else if (!bus.stall) begin
            if (bus.fetch_en) begin
              r_valid <= 1'b1;
              if (w_oob || w_misaligned) begin
                r_instr <= NOP_WORD;
                r_fault <= 1'b1;
              end else begin
                r_instr <= r_mem[w_rd_idx];
                r_fault <= 1'b0;
              end
            end else begin
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign bus.instruction = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.fetch_fault = r_fault;
  assign bus.load_ready  = w_load_ready;
  assign bus.load_busy   = (r_state != S_RUN);
endmodule
